// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory controller.
// Contents: FSM state encoding, big-endian byte-lane write-enable
// constants (bit 3 = byte offset 0) and the access-size enum.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_t;

  localparam logic [3:0] WE_B0 = 4'b1000;
  localparam logic [3:0] WE_B1 = 4'b0100;
  localparam logic [3:0] WE_B2 = 4'b0010;
  localparam logic [3:0] WE_B3 = 4'b0001;
  localparam logic [3:0] WE_H0 = 4'b1100;
  localparam logic [3:0] WE_H2 = 4'b0011;
  localparam logic [3:0] WE_W  = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for a big-endian 32-bit data bus.
// Ports:
//   addr_lo    in   2  byte offset within the word
//   size       in      access size (word / half / byte)
//   sign_ext   in   1  sign-extend sub-word loads
//   store_in   in  32  store data, right-justified
//   bus_in     in  32  bus read data
//   store_out  out 32  store data replicated onto all addressed lanes
//   we_mask    out  4  byte-lane enables for the access size/offset
//   load_out   out 32  extracted, right-justified, extended load data
//   misaligned out  1  half with odd offset, or word with nonzero offset
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_t       size,
  input  logic        sign_ext,
  input  logic [31:0] store_in,
  input  logic [31:0] bus_in,
  output logic [31:0] store_out,
  output logic [3:0]  we_mask,
  output logic [31:0] load_out,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = bus_in[31:24];
      2'd1:    byte_sel = bus_in[23:16];
      2'd2:    byte_sel = bus_in[15:8];
      default: byte_sel = bus_in[7:0];
    endcase
    half_sel = addr_lo[1] ? bus_in[15:0] : bus_in[31:16];
  end

  always_comb begin
    store_out  = store_in;
    we_mask    = WE_W;
    load_out   = bus_in;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        store_out = {4{store_in[7:0]}};
        we_mask   = WE_B0 >> addr_lo;
        load_out  = sign_ext ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      end
      SZ_HALF: begin
        store_out  = {2{store_in[15:0]}};
        we_mask    = addr_lo[1] ? WE_H2 : WE_H0;
        load_out   = sign_ext ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_controller.sv
// MEM-stage data-memory controller: turns load/store controls into
// word-aligned bus transactions, captures load data, raises M_Stall
// until the bus acknowledges, and flags misaligned accesses.
// Optional feature: define MEM_LLSC_EN for LL/SC link-register support.
// Ports:
//   clock, reset             core clock, synchronous active-high reset
//   DataIn, Address          store data and effective byte address
//   MemRead, MemWrite        load / store in MEM
//   MemByte, MemHalf         access size (neither = word)
//   MemSignExtend            sign-extend sub-word loads
//   LLSC, ERET               LL/SC qualifier, link clear
//   IF_Stall                 front-end stall, pipeline frozen while high
//   DataOut                  load result or SC status
//   M_Stall                  stall request to the hazard unit
//   EXC_AdEL, EXC_AdES       misaligned load / store
//   DataMem_*                data-bus request, WE lanes, address, data, ack
module mem_stage_controller
  import mem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] DataIn,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemByte,
  input  logic        MemHalf,
  input  logic        MemSignExtend,
  input  logic        LLSC,
  input  logic        ERET,
  input  logic        IF_Stall,
  output logic [31:0] DataOut,
  output logic        M_Stall,
  output logic        EXC_AdEL,
  output logic        EXC_AdES,
  output logic        DataMem_Read,
  output logic [3:0]  DataMem_Write,
  output logic [29:0] DataMem_Address,
  output logic [31:0] DataMem_Out,
  input  logic [31:0] DataMem_In,
  input  logic        DataMem_Ack
);

  state_t      state_q;
  logic [31:0] dout_q;

  // Copy of the access taken when the request is issued; drives the bus
  // while waiting so the transaction stays stable regardless of inputs.
  logic [31:0] hold_addr_q;
  logic [31:0] hold_data_q;
  size_t       hold_size_q;
  logic        hold_sext_q;
  logic        hold_rd_q;
  logic        hold_wr_q;
  logic        hold_llsc_q;

  logic        rd_live, wr_live;
  size_t       size_live;
  logic        in_wait, in_idle;
  logic [31:0] eff_addr, eff_data;
  size_t       eff_size;
  logic        eff_sext, eff_llsc;
  logic        bus_rd, bus_wr;
  logic [31:0] store_out, load_out, cap_val;
  logic [3:0]  we_mask;
  logic        misaligned;
  logic        sc_fail;
  logic        req_live, issue, bus_ack;

  // Read has priority if both controls are (illegally) high.
  assign rd_live   = MemRead;
  assign wr_live   = MemWrite & ~MemRead;
  assign size_live = MemByte ? SZ_BYTE : (MemHalf ? SZ_HALF : SZ_WORD);

  assign in_wait = (state_q == S_WAIT);
  assign in_idle = (state_q == S_IDLE);

  assign eff_addr = in_wait ? hold_addr_q : Address;
  assign eff_data = in_wait ? hold_data_q : DataIn;
  assign eff_size = in_wait ? hold_size_q : size_live;
  assign eff_sext = in_wait ? hold_sext_q : MemSignExtend;
  assign eff_llsc = in_wait ? hold_llsc_q : LLSC;
  assign bus_rd   = in_wait ? hold_rd_q   : rd_live;
  assign bus_wr   = in_wait ? hold_wr_q   : wr_live;

  mem_lane_align u_align (
    .addr_lo    (eff_addr[1:0]),
    .size       (eff_size),
    .sign_ext   (eff_sext),
    .store_in   (eff_data),
    .bus_in     (DataMem_In),
    .store_out  (store_out),
    .we_mask    (we_mask),
    .load_out   (load_out),
    .misaligned (misaligned)
  );

`ifdef MEM_LLSC_EN
  logic        link_q;
  logic [29:0] link_addr_q;

  assign sc_fail = wr_live & LLSC & ~(link_q & (link_addr_q == Address[31:2]));

  always_ff @(posedge clock) begin
    if (reset || ERET) begin
      link_q      <= 1'b0;
      link_addr_q <= '0;
    end else if (bus_ack && bus_rd && eff_llsc) begin
      link_q      <= 1'b1;
      link_addr_q <= eff_addr[31:2];
    end else if ((bus_ack && bus_wr && eff_llsc) ||
                 (in_idle && sc_fail && !misaligned)) begin
      link_q <= 1'b0;
    end
  end
`else
  logic unused_eret;
  assign unused_eret = ERET;
  assign sc_fail     = 1'b0;
`endif

  assign req_live = (rd_live | wr_live) & ~misaligned & ~sc_fail;
  assign issue    = (in_idle & req_live) | in_wait;
  assign bus_ack  = issue & DataMem_Ack;
  assign cap_val  = bus_rd ? load_out : ((bus_wr & eff_llsc) ? 32'd1 : '0);

  assign M_Stall         = ~reset & issue;
  assign DataMem_Read    = ~reset & issue & bus_rd;
  assign DataMem_Write   = (~reset & issue & bus_wr) ? we_mask : '0;
  assign DataMem_Address = eff_addr[31:2];
  assign DataMem_Out     = store_out;
  assign EXC_AdEL        = ~reset & in_idle & rd_live & misaligned;
  assign EXC_AdES        = ~reset & in_idle & wr_live & misaligned;
  assign DataOut         = (state_q == S_DONE) ? dout_q : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dout_q      <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      hold_size_q <= SZ_WORD;
      hold_sext_q <= 1'b0;
      hold_rd_q   <= 1'b0;
      hold_wr_q   <= 1'b0;
      hold_llsc_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_live) begin
            hold_addr_q <= Address;
            hold_data_q <= DataIn;
            hold_size_q <= size_live;
            hold_sext_q <= MemSignExtend;
            hold_rd_q   <= rd_live;
            hold_wr_q   <= wr_live;
            hold_llsc_q <= LLSC;
            if (DataMem_Ack) begin
              dout_q  <= cap_val;
              state_q <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (sc_fail && !misaligned) begin
            // Failed SC completes without a bus cycle, status 0.
            dout_q  <= '0;
            state_q <= S_DONE;
          end
        end
        S_WAIT: begin
          if (DataMem_Ack) begin
            dout_q  <= cap_val;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!IF_Stall) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  a_no_rd_wr: assert property (@(posedge clock) disable iff (reset)
                               !(MemRead && MemWrite));

endmodule

// File: tb/tb_mem_stage_controller.sv
module tb_mem_stage_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] DataIn, Address;
  logic        MemRead, MemWrite, MemByte, MemHalf, MemSignExtend;
  logic        LLSC, ERET, IF_Stall;
  logic [31:0] DataOut;
  logic        M_Stall, EXC_AdEL, EXC_AdES, DataMem_Read;
  logic [3:0]  DataMem_Write;
  logic [29:0] DataMem_Address;
  logic [31:0] DataMem_Out, DataMem_In;
  logic        DataMem_Ack;

  int vecs = 0;
  int errs = 0;
  int stalls;
  int reads;

  always #5 clock = ~clock;

  mem_stage_controller dut (
    .clock           (clock),
    .reset           (reset),
    .DataIn          (DataIn),
    .Address         (Address),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .MemByte         (MemByte),
    .MemHalf         (MemHalf),
    .MemSignExtend   (MemSignExtend),
    .LLSC            (LLSC),
    .ERET            (ERET),
    .IF_Stall        (IF_Stall),
    .DataOut         (DataOut),
    .M_Stall         (M_Stall),
    .EXC_AdEL        (EXC_AdEL),
    .EXC_AdES        (EXC_AdES),
    .DataMem_Read    (DataMem_Read),
    .DataMem_Write   (DataMem_Write),
    .DataMem_Address (DataMem_Address),
    .DataMem_Out     (DataMem_Out),
    .DataMem_In      (DataMem_In),
    .DataMem_Ack     (DataMem_Ack)
  );

  task idle_inputs;
    DataIn = '0; Address = '0; MemRead = 0; MemWrite = 0; MemByte = 0;
    MemHalf = 0; MemSignExtend = 0; LLSC = 0; ERET = 0; IF_Stall = 0;
    DataMem_In = '0; DataMem_Ack = 0;
  endtask

  // Advance one full cycle, returning at the falling edge.
  task step;
    @(posedge clock);
    @(negedge clock);
  endtask

  task test_reset;
    reset = 1; idle_inputs();
    step();
    MemRead = 1; Address = 32'h102;
    #1;
    vecs++; if (M_Stall !== 1'b0) begin errs++; $display("FAIL rst_stall: got %b want 0", M_Stall); end
    vecs++; if (DataMem_Read !== 1'b0) begin errs++; $display("FAIL rst_read: got %b want 0", DataMem_Read); end
    vecs++; if (EXC_AdEL !== 1'b0) begin errs++; $display("FAIL rst_adel: got %b want 0", EXC_AdEL); end
    MemRead = 0; MemWrite = 1; Address = 32'h100;
    #1;
    vecs++; if (DataMem_Write !== 4'b0000) begin errs++; $display("FAIL rst_we: got %b want 0000", DataMem_Write); end
    step();
    idle_inputs(); reset = 0;
    #1;
    vecs++; if (DataOut !== 32'h0) begin errs++; $display("FAIL rst_dout: got %h want 00000000", DataOut); end
    vecs++; if (M_Stall !== 1'b0) begin errs++; $display("FAIL rst_idle_stall: got %b want 0", M_Stall); end
  endtask

  task test_lw_wait;
    idle_inputs();
    MemRead = 1; Address = 32'h0000_0104; DataMem_In = 32'hDEAD_BEEF;
    stalls = 0;
    for (int c = 0; c < 3; c++) begin
      DataMem_Ack = (c == 2);
      #1;
      if (M_Stall) stalls++;
      vecs++; if (DataMem_Address !== 30'h41) begin errs++; $display("FAIL lw_addr c%0d: got %h want 41", c, DataMem_Address); end
      step();
    end
    DataMem_Ack = 0;
    #1;
    vecs++; if (stalls != 3) begin errs++; $display("FAIL lw_stall_cycles: got %0d want 3", stalls); end
    vecs++; if (M_Stall !== 1'b0) begin errs++; $display("FAIL lw_done_stall: got %b want 0", M_Stall); end
    vecs++; if (DataOut !== 32'hDEAD_BEEF) begin errs++; $display("FAIL lw_dout: got %h want deadbeef", DataOut); end
    vecs++; if (DataMem_Read !== 1'b0) begin errs++; $display("FAIL lw_done_read: got %b want 0", DataMem_Read); end
    idle_inputs();
    step();
    #1;
    vecs++; if (DataOut !== 32'h0) begin errs++; $display("FAIL lw_idle_dout: got %h want 00000000", DataOut); end
  endtask

  task test_sb;
    idle_inputs();
    MemWrite = 1; MemByte = 1; DataIn = 32'h0000_00A5; Address = 32'h0000_0201;
    DataMem_Ack = 1;
    #1;
    vecs++; if (DataMem_Write !== 4'b0100) begin errs++; $display("FAIL sb_we: got %b want 0100", DataMem_Write); end
    vecs++; if (DataMem_Out !== 32'hA5A5_A5A5) begin errs++; $display("FAIL sb_data: got %h want a5a5a5a5", DataMem_Out); end
    vecs++; if (M_Stall !== 1'b1) begin errs++; $display("FAIL sb_stall0: got %b want 1", M_Stall); end
    step();
    DataMem_Ack = 0;
    #1;
    vecs++; if (M_Stall !== 1'b0) begin errs++; $display("FAIL sb_stall1: got %b want 0", M_Stall); end
    vecs++; if (DataMem_Write !== 4'b0000) begin errs++; $display("FAIL sb_done_we: got %b want 0000", DataMem_Write); end
    idle_inputs();
    step();
  endtask

  task test_subword_loads;
    logic [31:0] addr_v [4];
    logic        half_v [4];
    logic        sext_v [4];
    logic [31:0] exp_v  [4];
    addr_v = '{32'h302, 32'h300, 32'h302, 32'h303};
    half_v = '{1'b1,    1'b0,    1'b0,    1'b0};
    sext_v = '{1'b1,    1'b0,    1'b1,    1'b1};
    exp_v  = '{32'hFFFF_8001, 32'h0000_0012, 32'hFFFF_FF80, 32'h0000_0001};
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      MemRead = 1; Address = addr_v[i]; MemHalf = half_v[i]; MemByte = ~half_v[i];
      MemSignExtend = sext_v[i]; DataMem_In = 32'h1234_8001; DataMem_Ack = 1;
      step();
      DataMem_Ack = 0; DataMem_In = '0;
      #1;
      vecs++; if (DataOut !== exp_v[i]) begin errs++; $display("FAIL subload%0d: got %h want %h", i, DataOut, exp_v[i]); end
      idle_inputs();
      step();
    end
  endtask

  task test_misaligned;
    idle_inputs();
    MemRead = 1; Address = 32'h0000_0102;
    #1;
    vecs++; if (EXC_AdEL !== 1'b1) begin errs++; $display("FAIL mis_adel: got %b want 1", EXC_AdEL); end
    vecs++; if (DataMem_Read !== 1'b0) begin errs++; $display("FAIL mis_read: got %b want 0", DataMem_Read); end
    vecs++; if (M_Stall !== 1'b0) begin errs++; $display("FAIL mis_stall: got %b want 0", M_Stall); end
    step();
    #1;
    vecs++; if (M_Stall !== 1'b0) begin errs++; $display("FAIL mis_stall_next: got %b want 0", M_Stall); end
    idle_inputs();
    MemWrite = 1; MemHalf = 1; Address = 32'h0000_0101; DataIn = 32'h1111_2222;
    #1;
    vecs++; if (EXC_AdES !== 1'b1) begin errs++; $display("FAIL mis_ades: got %b want 1", EXC_AdES); end
    vecs++; if (EXC_AdEL !== 1'b0) begin errs++; $display("FAIL mis_ades_adel: got %b want 0", EXC_AdEL); end
    vecs++; if (DataMem_Write !== 4'b0000) begin errs++; $display("FAIL mis_we: got %b want 0000", DataMem_Write); end
    Address = 32'h0000_0102;
    #1;
    vecs++; if (DataMem_Write !== 4'b0011) begin errs++; $display("FAIL sh2_we: got %b want 0011", DataMem_Write); end
    vecs++; if (EXC_AdES !== 1'b0) begin errs++; $display("FAIL sh2_ades: got %b want 0", EXC_AdES); end
    DataMem_Ack = 1;
    step();
    idle_inputs();
    step();
  endtask

  task test_if_stall;
    idle_inputs();
    MemRead = 1; Address = 32'h100; DataMem_In = 32'hCAFE_F00D; DataMem_Ack = 1; IF_Stall = 1;
    reads = 0;
    #1;
    if (DataMem_Read) reads++;
    step();
    DataMem_Ack = 0; DataMem_In = '0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) IF_Stall = 0;
      #1;
      if (DataMem_Read) reads++;
      vecs++; if (DataOut !== 32'hCAFE_F00D) begin errs++; $display("FAIL ifs_dout c%0d: got %h want cafef00d", c, DataOut); end
      vecs++; if (M_Stall !== 1'b0) begin errs++; $display("FAIL ifs_stall c%0d: got %b want 0", c, M_Stall); end
      step();
    end
    idle_inputs();
    #1;
    vecs++; if (reads != 1) begin errs++; $display("FAIL ifs_reads: got %0d want 1", reads); end
    vecs++; if (DataOut !== 32'h0) begin errs++; $display("FAIL ifs_idle_dout: got %h want 00000000", DataOut); end
  endtask

  task test_reset_wait;
    idle_inputs();
    MemRead = 1; Address = 32'h180;
    step();
    #1;
    vecs++; if (M_Stall !== 1'b1) begin errs++; $display("FAIL rw_wait_stall: got %b want 1", M_Stall); end
    reset = 1; idle_inputs();
    step();
    reset = 0; DataMem_Ack = 1; DataMem_In = 32'h5555_5555;
    #1;
    vecs++; if (DataMem_Read !== 1'b0) begin errs++; $display("FAIL rw_read: got %b want 0", DataMem_Read); end
    vecs++; if (M_Stall !== 1'b0) begin errs++; $display("FAIL rw_stall: got %b want 0", M_Stall); end
    step();
    DataMem_Ack = 0;
    #1;
    vecs++; if (DataOut !== 32'h0) begin errs++; $display("FAIL rw_late_ack_dout: got %h want 00000000", DataOut); end
    vecs++; if (M_Stall !== 1'b0) begin errs++; $display("FAIL rw_late_ack_stall: got %b want 0", M_Stall); end
  endtask

  task do_ll;
    idle_inputs();
    MemRead = 1; LLSC = 1; Address = 32'h400; DataMem_In = 32'h77; DataMem_Ack = 1;
    step();
    idle_inputs();
    step();
  endtask

  task do_sc(input logic [31:0] addr, input logic [3:0] exp_we,
             input logic exp_stall, input logic [31:0] exp_dout, input int id);
    idle_inputs();
    MemWrite = 1; LLSC = 1; Address = addr; DataIn = 32'h9999_0000; DataMem_Ack = 1;
    #1;
    vecs++; if (DataMem_Write !== exp_we) begin errs++; $display("FAIL sc%0d_we: got %b want %b", id, DataMem_Write, exp_we); end
    vecs++; if (M_Stall !== exp_stall) begin errs++; $display("FAIL sc%0d_stall: got %b want %b", id, M_Stall, exp_stall); end
    step();
    DataMem_Ack = 0;
    #1;
    vecs++; if (DataOut !== exp_dout) begin errs++; $display("FAIL sc%0d_dout: got %h want %h", id, DataOut, exp_dout); end
    idle_inputs();
    step();
  endtask

  task test_llsc;
`ifdef MEM_LLSC_EN
    do_ll();
    do_sc(32'h404, 4'b0000, 1'b0, 32'h0, 0);
    do_ll();
    do_sc(32'h400, 4'b1111, 1'b1, 32'h1, 1);
    do_sc(32'h400, 4'b0000, 1'b0, 32'h0, 2);
    do_ll();
    idle_inputs(); ERET = 1;
    step();
    ERET = 0;
    do_sc(32'h400, 4'b0000, 1'b0, 32'h0, 3);
`else
    do_ll();
    do_sc(32'h404, 4'b1111, 1'b1, 32'h1, 0);
`endif
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    @(negedge clock);
    test_reset();
    test_lw_wait();
    test_sb();
    test_subword_loads();
    test_misaligned();
    test_if_stall();
    test_reset_wait();
    test_llsc();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
